mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch (if) and data (dm).
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_done,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;
    logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BeW-1:0]    mem_be_q, mem_be_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic grant_if;
    logic grant_dm;

    always_comb begin
        grant_if = if_req && (!dm_req || (starve_cnt_q == CntMax));
        grant_dm = dm_req && !grant_if;
    end

    always_comb begin
        state_d      = state_q;
        owner_dm_d   = owner_dm_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_done_d    = 1'b0;
        dm_done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_if) begin
                    state_d      = StBusy;
                    owner_dm_d   = 1'b0;
                    starve_cnt_d = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    mem_be_d     = '1;
                end else if (grant_dm) begin
                    state_d     = StBusy;
                    owner_dm_d  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    // Only a waiting fetch accumulates starvation.
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != CntMax) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    state_d   = StResp;
                    mem_req_d = 1'b0;
                    if (owner_dm_q) begin
                        dm_done_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_dm_q   <= 1'b0;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_done_q    <= 1'b0;
            dm_done_q    <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_dm_q   <= owner_dm_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_done_q    <= if_done_d;
            dm_done_q    <= dm_done_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model with programmable ack delay and a scoreboard
// of expected grants checked on every cycle the shared port is busy and on every done pulse.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        sb[$];
    int          vectors = 0;
    int          fails   = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;
    int          ack_delay = 0;
    logic        manual_ack = 1'b0;
    int          req_age;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory acks in the req_age'th cycle of mem_req (0 = same cycle mem_req rises).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_age <= 0;
        else if (mem_req && !mem_ack) req_age <= req_age + 1;
        else req_age <= 0;
    end
    assign mem_ack   = (mem_req && (req_age == ack_delay)) || manual_ack;
    assign mem_rdata = mem_model(mem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(if_done || dm_done) && n < 30);
        chk("done_within_bound", {31'b0, if_done | dm_done}, 32'd1);
    endtask

    function automatic void push_if(input logic [31:0] a);
        txn_t t;
        t = '{is_dm: 1'b0, we: 1'b0, addr: a, wdata: 32'h0, be: 4'hF};
        sb.push_back(t);
    endfunction

    function automatic void push_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] be);
        txn_t t;
        t = '{is_dm: 1'b1, we: we, addr: a, wdata: wd, be: be};
        sb.push_back(t);
    endfunction

    // Scoreboard monitor: port fields held against the head entry; head retired on done.
    always @(negedge clk) begin
        txn_t t;
        if (rst_n) begin
            if (mem_req) begin
                chk("sb_nonempty_at_req", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    t = sb[0];
                    chk("mem_we", {31'b0, mem_we}, {31'b0, t.we});
                    chk("mem_addr", mem_addr, t.addr);
                    chk("mem_be", {28'b0, mem_be}, {28'b0, t.be});
                    if (t.is_dm && t.we) chk("mem_wdata", mem_wdata, t.wdata);
                end
            end
            if (if_done || dm_done) begin
                chk("single_done", {31'b0, if_done & dm_done}, 32'd0);
                chk("sb_nonempty_at_done", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    t = sb.pop_front();
                    chk("done_owner", {31'b0, dm_done}, {31'b0, t.is_dm});
                    if (!t.is_dm) exp_if_rdata = mem_model(t.addr);
                    else if (!t.we) exp_dm_rdata = mem_model(t.addr);
                end
            end
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("dm_rdata", dm_rdata, exp_dm_rdata);
        end
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_be    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_dones", {30'b0, if_done, dm_done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Lone fetch, zero-wait memory
        if_addr = 32'h100;
        if_req  = 1'b1;
        push_if(32'h100);
        tick();
        chk("fetch_mem_req_c1", {31'b0, mem_req}, 32'd1);
        chk("fetch_mem_addr_c1", mem_addr, 32'h100);
        tick();
        chk("fetch_if_done_c2", {31'b0, if_done}, 32'd1);
        chk("fetch_if_rdata_c2", if_rdata, 32'h0000_0013);
        if_req = 1'b0;
        tick();
        chk("fetch_done_cleared_c3", {31'b0, if_done}, 32'd0);
        chk("fetch_mem_req_c3", {31'b0, mem_req}, 32'd0);

        // Simultaneous requests: dm first, if three cycles later
        if_addr  = 32'h104;
        if_req   = 1'b1;
        dm_addr  = 32'h2000;
        dm_we    = 1'b0;
        dm_be    = 4'hF;
        dm_wdata = '0;
        dm_req   = 1'b1;
        push_dm(1'b0, 32'h2000, 32'h0, 4'hF);
        push_if(32'h104);
        tick();
        chk("simul_dm_first_addr", mem_addr, 32'h2000);
        tick();
        chk("simul_dm_done", {31'b0, dm_done}, 32'd1);
        dm_req = 1'b0;
        tick();
        chk("simul_no_done_c3", {30'b0, if_done, dm_done}, 32'd0);
        tick();
        chk("simul_if_addr_c4", mem_addr, 32'h104);
        tick();
        chk("simul_if_done_c5", {31'b0, if_done}, 32'd1);
        if_req = 1'b0;
        tick();

        // Starvation: fetch held, data re-requested back-to-back
        if_addr = 32'h300;
        if_req  = 1'b1;
        dm_addr = 32'h1000;
        dm_req  = 1'b1;
        for (int i = 0; i < 4; i++) push_dm(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'hF);
        push_if(32'h300);
        for (int i = 0; i < 4; i++) begin
            wait_done(n);
            chk("starve_dm_grant", {31'b0, dm_done}, 32'd1);
            dm_addr = 32'h1000 + 32'(4 * (i + 1));
            if (i == 3) dm_req = 1'b0;
        end
        wait_done(n);
        chk("starve_if_grant", {31'b0, if_done}, 32'd1);
        if_req = 1'b0;
        chk("starve_cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
        tick();

        // Store with five wait states
        ack_delay = 5;
        dm_we     = 1'b1;
        dm_addr   = 32'h40;
        dm_wdata  = 32'hDEAD_BEEF;
        dm_be     = 4'h3;
        dm_req    = 1'b1;
        push_dm(1'b1, 32'h40, 32'hDEAD_BEEF, 4'h3);
        wait_done(n);
        chk("store_latency", 32'(n), 32'd7);
        chk("store_dm_done", {31'b0, dm_done}, 32'd1);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        chk("store_single_done_a", {31'b0, dm_done}, 32'd0);
        tick();
        chk("store_single_done_b", {31'b0, dm_done}, 32'd0);
        ack_delay = 0;

        // Reset while BUSY, then a stray ack in IDLE
        ack_delay = 10;
        dm_addr   = 32'h80;
        dm_be     = 4'hF;
        dm_req    = 1'b1;
        push_dm(1'b0, 32'h80, 32'h0, 4'hF);
        repeat (3) tick();
        chk("midbusy_mem_req", {31'b0, mem_req}, 32'd1);
        rst_n  = 1'b0;
        dm_req = 1'b0;
        sb.delete();
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        #1;
        chk("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("async_rst_mem_addr", mem_addr, 32'd0);
        chk("async_rst_mem_wdata", mem_wdata, 32'd0);
        chk("async_rst_if_rdata", if_rdata, 32'd0);
        chk("async_rst_dm_rdata", dm_rdata, 32'd0);
        tick();
        rst_n     = 1'b1;
        ack_delay = 0;
        tick();
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stray_ack_idle", {29'b0, mem_req, if_done, dm_done}, 32'd0);
        end

        // Fetch after reset still sees minimum latency
        if_addr = 32'h200;
        if_req  = 1'b1;
        push_if(32'h200);
        wait_done(n);
        chk("post_rst_fetch_latency", 32'(n), 32'd2);
        if_req = 1'b0;
        repeat (2) tick();
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
